// File: rtl/line_fill_pkg.sv
// Shared types and parameter helpers for the line-fill memory responder.
// Contents:
//   lf_state_t        - responder FSM state encoding
//   nr_words_per_line - 32-bit words per cache line for a given byte-offset width
//   line_size         - line width in bits for a given byte-offset width
package line_fill_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FETCH,
    RESP
  } lf_state_t;

  function automatic int unsigned nr_words_per_line(input int unsigned byte_offset_bits);
    return (2 ** byte_offset_bits) / 4;
  endfunction

  function automatic int unsigned line_size(input int unsigned byte_offset_bits);
    return 32 * nr_words_per_line(byte_offset_bits);
  endfunction

endpackage

// File: rtl/line_fill_memory_if.sv
// Line-fill request/response bundle between a cache (master) and the
// memory-side responder (slave).
// Signals:
//   mem_addr       master->slave  byte address of the requested line
//   mem_read_en    master->slave  fill request, held until valid is seen
//   mem_read_valid slave->master  one-cycle pulse, line data valid
//   mem_read_data  slave->master  line data, word k at [32k+31:32k]
interface line_fill_memory_if #(
  parameter int unsigned LineSize = 256
) ();

  logic [31:0]         mem_addr;
  logic                mem_read_en;
  logic                mem_read_valid;
  logic [LineSize-1:0] mem_read_data;

  modport master (
    output mem_addr,
    output mem_read_en,
    input  mem_read_valid,
    input  mem_read_data
  );

  modport slave (
    input  mem_addr,
    input  mem_read_en,
    output mem_read_valid,
    output mem_read_data
  );

endinterface

// File: rtl/line_fill_storage.sv
// Word-organised register storage for the line-fill responder.
// Asynchronous read port; synchronous write port only when LINE_FILL_WRITE_EN
// is defined, otherwise the contents are only ever set (to zero) by reset.
// Ports:
//   clk_i, rstn_i  clock, async active-low reset (clears every word)
//   rd_idx_i       word index to read
//   rd_word_o      word at rd_idx_i (combinational)
//   wr_en_i        (LINE_FILL_WRITE_EN) write strobe
//   wr_idx_i       (LINE_FILL_WRITE_EN) word index to write
//   wr_word_i      (LINE_FILL_WRITE_EN) write data
module line_fill_storage #(
  parameter int unsigned MemAddrBits = 10
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [MemAddrBits-1:0] rd_idx_i,
  output logic [31:0]            rd_word_o
`ifdef LINE_FILL_WRITE_EN
  ,
  input  logic                   wr_en_i,
  input  logic [MemAddrBits-1:0] wr_idx_i,
  input  logic [31:0]            wr_word_i
`endif
);

  localparam int unsigned Depth = 2 ** MemAddrBits;

  logic [31:0] mem_q [Depth];

`ifdef LINE_FILL_WRITE_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_word_i;
    end
  end
`else
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end
  end
`endif

  // Async read: a same-edge write is not yet visible, so a fetch on that
  // edge captures the old word.
  assign rd_word_o = mem_q[rd_idx_i];

endmodule

// File: rtl/line_fill_memory.sv
// Memory-side responder for the cache line-fill interface. Accepts a held
// read request, waits LatencyCycles edges, assembles one line a word per
// cycle into an internal buffer, then publishes it with a one-cycle valid.
// Optional feature: define LINE_FILL_WRITE_EN to add the word write port.
// Ports:
//   clk_i             clock, rising edge
//   rstn_i            async active-low reset
//   bus               line_fill_memory_if.slave (addr, read_en, valid, data)
//   busy_o            high whenever the FSM is not IDLE
//   mem_write_en_i    (LINE_FILL_WRITE_EN) word write strobe
//   mem_write_addr_i  (LINE_FILL_WRITE_EN) byte address of the word
//   mem_write_word_i  (LINE_FILL_WRITE_EN) write data
//
// state | meaning
// IDLE  | waiting for mem_read_en
// WAIT  | counting access latency
// FETCH | capturing one line word per edge
// RESP  | data_o valid, one cycle
module line_fill_memory
  import line_fill_pkg::*;
#(
  parameter int unsigned ByteOffsetBits = 5,
  parameter int unsigned MemAddrBits    = 10,
  parameter int unsigned LatencyCycles  = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  line_fill_memory_if.slave bus,
  output logic              busy_o
`ifdef LINE_FILL_WRITE_EN
  ,
  input  logic              mem_write_en_i,
  input  logic [31:0]       mem_write_addr_i,
  input  logic [31:0]       mem_write_word_i
`endif
);

  localparam int unsigned NrWordsPerLine = nr_words_per_line(ByteOffsetBits);
  localparam int unsigned LineSize       = line_size(ByteOffsetBits);
  localparam int unsigned WordSelBits    = ByteOffsetBits - 2;
  localparam int unsigned WordCntBits    = (WordSelBits > 0) ? WordSelBits : 1;
  localparam int unsigned LatCntBits     = (LatencyCycles > 1) ? $clog2(LatencyCycles) : 1;

  localparam logic [MemAddrBits-1:0] LineMask = MemAddrBits'((1 << WordSelBits) - 1);
  localparam logic [WordCntBits-1:0] LastWord = WordCntBits'(NrWordsPerLine - 1);
  localparam logic [LatCntBits-1:0]  LatLoad  = LatCntBits'(LatencyCycles - 1);

  lf_state_t state_q, state_d;

  logic [MemAddrBits-1:0] req_idx;
  logic [MemAddrBits-1:0] base_idx_q;
  logic [MemAddrBits-1:0] rd_idx;
  logic [WordCntBits-1:0] word_cnt_q;
  logic [LatCntBits-1:0]  lat_cnt_q;
  logic [LineSize-1:0]    line_buf_q;
  logic [LineSize-1:0]    line_merged;
  logic [LineSize-1:0]    data_q;
  logic [31:0]            rd_word;
  logic                   accept;
  logic                   capture;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_addr[31:MemAddrBits+2], bus.mem_addr[1:0]};

  // Line base: word index with the in-line word bits cleared. Index
  // arithmetic stays MemAddrBits wide so a line near the top wraps.
  assign req_idx = bus.mem_addr[MemAddrBits+1:2] & ~LineMask;
  assign rd_idx  = base_idx_q + MemAddrBits'(word_cnt_q);

  line_fill_storage #(
    .MemAddrBits(MemAddrBits)
  ) u_storage (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .rd_idx_i  (rd_idx),
    .rd_word_o (rd_word)
`ifdef LINE_FILL_WRITE_EN
    ,
    .wr_en_i   (mem_write_en_i),
    .wr_idx_i  (mem_write_addr_i[MemAddrBits+1:2]),
    .wr_word_i (mem_write_word_i)
`endif
  );

`ifdef LINE_FILL_WRITE_EN
  logic unused_wr_bits;
  assign unused_wr_bits = ^{mem_write_addr_i[31:MemAddrBits+2], mem_write_addr_i[1:0]};
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Dropping the request in WAIT or FETCH abandons the fill; RESP ignores
  // the request because the cache releases it combinationally on valid.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_read_en) begin
          accept  = 1'b1;
          state_d = (LatencyCycles == 0) ? FETCH : WAIT;
        end
      end
      WAIT: begin
        if (!bus.mem_read_en)     state_d = IDLE;
        else if (lat_cnt_q == '0) state_d = FETCH;
      end
      FETCH: begin
        if (!bus.mem_read_en) begin
          state_d = IDLE;
        end else begin
          capture = 1'b1;
          if (word_cnt_q == LastWord) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    line_merged = line_buf_q;
    line_merged[word_cnt_q*32 +: 32] = rd_word;
  end

  // data_q only moves when the last word lands, so the published line never
  // shows a partially assembled fill.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      base_idx_q <= '0;
      word_cnt_q <= '0;
      lat_cnt_q  <= '0;
      line_buf_q <= '0;
      data_q     <= '0;
    end else begin
      if (accept) begin
        base_idx_q <= req_idx;
        lat_cnt_q  <= LatLoad;
        word_cnt_q <= '0;
      end
      if (state_q == WAIT && lat_cnt_q != '0) begin
        lat_cnt_q <= lat_cnt_q - 1'b1;
      end
      if (capture) begin
        line_buf_q <= line_merged;
        word_cnt_q <= word_cnt_q + 1'b1;
        if (word_cnt_q == LastWord) data_q <= line_merged;
      end
    end
  end

  assign bus.mem_read_valid = (state_q == RESP);
  assign bus.mem_read_data  = data_q;
  assign busy_o             = (state_q != IDLE);

endmodule
